// File: rtl/rv32i_decoder_stage.sv
// RV32I instruction decode stage: combinational decode feeding the ID/EX register.
// The register holds on stall and loads an all-zero bubble on flush (flush wins).
module rv32i_decoder_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instruction,
  output logic [4:0]  rs1_addr,
  output logic [4:0]  rs2_addr,
  output logic [4:0]  rd_addr,
  output logic [31:0] imm,
  output logic [3:0]  alu_op,
  output logic        reg_write,
  output logic        alu_src,
  output logic        mem_read,
  output logic        mem_write,
  output logic        mem_to_reg,
  output logic        branch,
  output logic        jump,
  output logic        jump_reg
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I_ALU  = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu_op;
    logic        reg_write;
    logic        alu_src;
    logic        mem_read;
    logic        mem_write;
    logic        mem_to_reg;
    logic        branch;
    logic        jump;
    logic        jump_reg;
  } id_ex_t;

  // alt selects SUB/SRA; callers only pass it when the opcode permits it
  function automatic logic [3:0] alu_from_funct3(input logic [2:0] f3, input logic alt);
    logic [3:0] op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      3'b111:  op = ALU_AND;
      default: op = ALU_ADD;
    endcase
    return op;
  endfunction

  id_ex_t     dec_s;
  id_ex_t     id_ex_d;
  id_ex_t     id_ex_q;
  logic [6:0] opcode_s;
  logic [2:0] funct3_s;
  logic [31:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;

  assign opcode_s = instruction[6:0];
  assign funct3_s = instruction[14:12];
  assign imm_i_s  = {{20{instruction[31]}}, instruction[31:20]};
  assign imm_s_s  = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
  assign imm_b_s  = {{19{instruction[31]}}, instruction[31], instruction[7],
                     instruction[30:25], instruction[11:8], 1'b0};
  assign imm_u_s  = {instruction[31:12], 12'h000};
  assign imm_j_s  = {{11{instruction[31]}}, instruction[31], instruction[19:12],
                     instruction[20], instruction[30:21], 1'b0};

  // Combinational decode of the current instruction word
  always_comb begin
    dec_s     = '0;
    dec_s.rs1 = instruction[19:15];
    dec_s.rs2 = instruction[24:20];
    case (opcode_s)
      OP_R: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_op    = alu_from_funct3(funct3_s, instruction[30]);
      end
      OP_I_ALU: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.imm       = imm_i_s;
        dec_s.alu_op    = alu_from_funct3(funct3_s, (funct3_s == 3'b101) & instruction[30]);
      end
      OP_LOAD: begin
        dec_s.reg_write  = 1'b1;
        dec_s.alu_src    = 1'b1;
        dec_s.mem_read   = 1'b1;
        dec_s.mem_to_reg = 1'b1;
        dec_s.imm        = imm_i_s;
      end
      OP_STORE: begin
        dec_s.alu_src   = 1'b1;
        dec_s.mem_write = 1'b1;
        dec_s.imm       = imm_s_s;
      end
      OP_BRANCH: begin
        dec_s.branch = 1'b1;
        dec_s.imm    = imm_b_s;
        case (funct3_s[2:1])
          2'b10:   dec_s.alu_op = ALU_SLT;
          2'b11:   dec_s.alu_op = ALU_SLTU;
          default: dec_s.alu_op = ALU_SUB;
        endcase
      end
      OP_JAL: begin
        dec_s.reg_write = 1'b1;
        dec_s.jump      = 1'b1;
        dec_s.imm       = imm_j_s;
      end
      OP_JALR: begin
        dec_s.reg_write = 1'b1;
        dec_s.jump_reg  = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.imm       = imm_i_s;
      end
      OP_LUI: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.alu_op    = ALU_PASS_B;
        dec_s.imm       = imm_u_s;
      end
      OP_AUIPC: begin
        dec_s.reg_write = 1'b1;
        dec_s.alu_src   = 1'b1;
        dec_s.imm       = imm_u_s;
      end
      default: begin
        dec_s     = '0;
        dec_s.rs1 = instruction[19:15];
        dec_s.rs2 = instruction[24:20];
      end
    endcase
    // rd is only meaningful when something is written back
    if (dec_s.reg_write) begin
      dec_s.rd = instruction[11:7];
    end else begin
      dec_s.rd = 5'd0;
    end
  end

  // Pipeline register next-state: flush beats stall beats a new decode
  always_comb begin
    id_ex_d = dec_s;
    if (flush) begin
      id_ex_d = '0;
    end else if (stall) begin
      id_ex_d = id_ex_q;
    end else begin
      id_ex_d = dec_s;
    end
  end

  // ID/EX register with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      id_ex_q <= '0;
    end else begin
      id_ex_q <= id_ex_d;
    end
  end

  assign rs1_addr   = id_ex_q.rs1;
  assign rs2_addr   = id_ex_q.rs2;
  assign rd_addr    = id_ex_q.rd;
  assign imm        = id_ex_q.imm;
  assign alu_op     = id_ex_q.alu_op;
  assign reg_write  = id_ex_q.reg_write;
  assign alu_src    = id_ex_q.alu_src;
  assign mem_read   = id_ex_q.mem_read;
  assign mem_write  = id_ex_q.mem_write;
  assign mem_to_reg = id_ex_q.mem_to_reg;
  assign branch     = id_ex_q.branch;
  assign jump       = id_ex_q.jump;
  assign jump_reg   = id_ex_q.jump_reg;

endmodule

// File: tb/tb_rv32i_decoder_stage.sv
// Self-checking bench for rv32i_decoder_stage: directed instruction table, randomized
// stream with stall/flush, and asynchronous reset, all against a behavioural model.
module tb_rv32i_decoder_stage;

  logic        clk;
  logic        rst_n;
  logic        stall;
  logic        flush;
  logic [31:0] instruction;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm;
  logic [3:0]  alu_op;
  logic        reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg;

  int n_cmp  = 0;
  int n_fail = 0;

  // {rs1, rs2, rd, imm, alu_op, reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg}
  logic [58:0] got;
  logic [58:0] exp_q;

  rv32i_decoder_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush), .instruction(instruction),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr), .imm(imm), .alu_op(alu_op),
    .reg_write(reg_write), .alu_src(alu_src), .mem_read(mem_read), .mem_write(mem_write),
    .mem_to_reg(mem_to_reg), .branch(branch), .jump(jump), .jump_reg(jump_reg)
  );

  assign got = {rs1_addr, rs2_addr, rd_addr, imm, alu_op,
                reg_write, alu_src, mem_read, mem_write, mem_to_reg, branch, jump, jump_reg};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference decode written from the instruction-set rules
  function automatic logic [58:0] ref_decode(input logic [31:0] i);
    int f3_alu [8] = '{0, 2, 3, 4, 5, 6, 8, 9};
    int op = 0;
    int im = 0;
    int f3 = int'(i[14:12]);
    bit rw = 0, as = 0, mr = 0, mw = 0, mtr = 0, br = 0, j = 0, jr = 0;
    logic signed [11:0] s12;
    logic signed [12:0] s13;
    logic signed [20:0] s21;
    logic [4:0] rd;
    case (i[6:0])
      7'b0110011: begin
        rw = 1; op = f3_alu[f3];
        if (f3 == 0 && i[30]) op = 1;
        if (f3 == 5 && i[30]) op = 7;
      end
      7'b0010011: begin
        rw = 1; as = 1; op = f3_alu[f3];
        if (f3 == 5 && i[30]) op = 7;
        s12 = i[31:20]; im = s12;
      end
      7'b0000011: begin rw = 1; as = 1; mr = 1; mtr = 1; s12 = i[31:20]; im = s12; end
      7'b0100011: begin as = 1; mw = 1; s12 = {i[31:25], i[11:7]}; im = s12; end
      7'b1100011: begin
        br = 1;
        op = (f3 >= 6) ? 4 : ((f3 >= 4) ? 3 : 1);
        s13 = {i[31], i[7], i[30:25], i[11:8], 1'b0}; im = s13;
      end
      7'b1101111: begin
        rw = 1; j = 1;
        s21 = {i[31], i[19:12], i[20], i[30:21], 1'b0}; im = s21;
      end
      7'b1100111: begin rw = 1; jr = 1; as = 1; s12 = i[31:20]; im = s12; end
      7'b0110111: begin rw = 1; as = 1; op = 10; im = int'(i[31:12]) * 4096; end
      7'b0010111: begin rw = 1; as = 1; op = 0;  im = int'(i[31:12]) * 4096; end
      default: begin end
    endcase
    rd = rw ? i[11:7] : 5'd0;
    return {i[19:15], i[24:20], rd, im[31:0], op[3:0], rw, as, mr, mw, mtr, br, j, jr};
  endfunction

  // One clock with the given inputs; advances the model and leaves time at edge+1
  task automatic drive_cycle(input logic [31:0] ins, input logic st, input logic fl);
    instruction = ins;
    stall       = st;
    flush       = fl;
    @(posedge clk);
    if (!rst_n)     exp_q = '0;
    else if (fl)    exp_q = '0;
    else if (!st)   exp_q = ref_decode(ins);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; instruction = 32'h007302b3;
    exp_q = '0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (got !== 59'd0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", got, 59'd0);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [31:0] ins_t [13] = '{32'h007302b3, 32'h00a48433, 32'hfff10093, 32'h00530293,
                                32'h0081a283, 32'h0040a623, 32'h00208263, 32'h008000ef,
                                32'h006200e7, 32'h123453b7, 32'h00010197, 32'h00000000,
                                32'h40c5d533};
    logic [4:0]  rd_t  [13] = '{5'd5, 5'd8, 5'd1, 5'd5, 5'd5, 5'd0, 5'd0, 5'd1,
                                5'd1, 5'd7, 5'd3, 5'd0, 5'd10};
    logic [31:0] imm_t [13] = '{32'h0, 32'h0, 32'hffffffff, 32'h5, 32'h8, 32'hc, 32'h4,
                                32'h8, 32'h6, 32'h12345000, 32'h00010000, 32'h0, 32'h0};
    logic [3:0]  op_t  [13] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd0,
                                4'd0, 4'd10, 4'd0, 4'd0, 4'd7};
    for (int k = 0; k < 13; k++) begin
      drive_cycle(ins_t[k], 1'b0, 1'b0);
      n_cmp++;
      if (got !== exp_q) begin
        n_fail++;
        $display("FAIL directed_model[%0d] ins=%h got=%h want=%h", k, ins_t[k], got, exp_q);
      end
      n_cmp++;
      if ({rd_addr, imm, alu_op} !== {rd_t[k], imm_t[k], op_t[k]}) begin
        n_fail++;
        $display("FAIL directed_fields[%0d] ins=%h rd/imm/op got=%0d/%h/%0d want=%0d/%h/%0d",
                 k, ins_t[k], rd_addr, imm, alu_op, rd_t[k], imm_t[k], op_t[k]);
      end
    end
  endtask

  task automatic test_stall_flush();
    drive_cycle(32'h007302b3, 1'b0, 1'b0);
    drive_cycle(32'h0081a283, 1'b1, 1'b0);
    n_cmp++;
    if (got !== ref_decode(32'h007302b3) || got !== exp_q) begin
      n_fail++;
      $display("FAIL stall_hold got=%h want=%h", got, ref_decode(32'h007302b3));
    end
    drive_cycle(32'h0081a283, 1'b1, 1'b1);
    n_cmp++;
    if (got !== 59'd0) begin
      n_fail++;
      $display("FAIL flush_over_stall got=%h want=%h", got, 59'd0);
    end
    drive_cycle(32'h0081a283, 1'b0, 1'b0);
    n_cmp++;
    if (got !== exp_q) begin
      n_fail++;
      $display("FAIL after_flush got=%h want=%h", got, exp_q);
    end
  endtask

  task automatic test_async_reset();
    drive_cycle(32'h00a48433, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (got !== 59'd0) begin
      n_fail++;
      $display("FAIL async_reset got=%h want=%h", got, 59'd0);
    end
    exp_q = '0;
    drive_cycle(32'h00530293, 1'b0, 1'b0);
    #2;
    rst_n = 1'b1;
    drive_cycle(32'h0040a623, 1'b0, 1'b0);
    n_cmp++;
    if (got !== exp_q || got !== ref_decode(32'h0040a623)) begin
      n_fail++;
      $display("FAIL reset_release got=%h want=%h", got, ref_decode(32'h0040a623));
    end
  endtask

  task automatic test_random();
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                             7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [2:0]  bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] r;
    int sel;
    for (int k = 0; k < 400; k++) begin
      r   = $urandom;
      sel = $urandom_range(0, 10);
      if (sel < 9) r[6:0] = ops[sel];
      if (r[6:0] == 7'b1100011) r[14:12] = bf3[$urandom_range(0, 5)];
      drive_cycle(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 9) == 0));
      n_cmp++;
      if (got !== exp_q) begin
        n_fail++;
        $display("FAIL random[%0d] ins=%h st=%0d fl=%0d got=%h want=%h",
                 k, r, stall, flush, got, exp_q);
      end
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall_flush();
    test_random();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
